vfpu_job_ctrl: RTL
==================

VFPU_JOB_CTRL -- requirements
Module: vfpu_job_ctrl

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16: width of the element-count field.
REQ-002 SHALL have parameter OP_WIDTH, default 3: width of the VFPU opcode field.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, legal range 1..255: maximum number of operand pairs issued whose results have not yet been retired.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  job start strobe.
REQ-007 SHALL have port len_i  in  LEN_WIDTH  job element count, sampled with start_i.
REQ-008 SHALL have port op_i  in  OP_WIDTH  job opcode, sampled with start_i.
REQ-009 SHALL have port issue_fire_i  in  1  operand-pair handshake completed this cycle (both sinks valid&ready).
REQ-010 SHALL have port result_fire_i  in  1  result-stream handshake completed this cycle.
REQ-011 SHALL have port issue_en_o  out  1  permits the streamer to accept operands (ANDed into sink ready).
REQ-012 SHALL have port op_o  out  OP_WIDTH  latched opcode driven to the VFPU control.
REQ-013 SHALL have port busy_o  out  1  job in progress.
REQ-014 SHALL have port done_o  out  1  one-cycle job-complete pulse.
REQ-015 SHALL have port error_o  out  1  sticky protocol-error flag.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; busy_o=1 in RUN and DRAIN only.
REQ-017 IDLE: start_i=1 with len_i!=0 SHALL latch len_i and op_i, clear the issued/retired counters, and enter RUN next cycle.
REQ-018 IDLE: start_i=1 with len_i==0 SHALL go to DONE next cycle without entering RUN; op_o SHALL still be updated.
REQ-019 start_i in any state other than IDLE SHALL be ignored, with no change to latched values.
REQ-020 issue_en_o SHALL be 1 only in RUN with issued<len and (issued-retired)<MAX_OUTSTANDING; it is combinational from registered state.
REQ-021 issue_fire_i SHALL increment issued only when issue_en_o=1; issue_fire_i with issue_en_o=0 SHALL set error_o and SHALL NOT count.
REQ-022 result_fire_i in RUN/DRAIN with retired<issued SHALL increment retired; in any other case it SHALL set error_o and SHALL NOT count.
REQ-023 Simultaneous issue_fire_i and result_fire_i SHALL both be counted in the same cycle, leaving outstanding unchanged.
REQ-024 RUN -> DRAIN SHALL occur in the cycle after issued reaches len; DRAIN -> DONE SHALL occur in the cycle after retired reaches len.
REQ-025 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-026 Latency: start_i at cycle t gives busy_o=1 at t+1; the final result_fire_i at cycle t gives done_o=1 at t+2 (DRAIN at t+1) and busy_o=0 at t+2.
REQ-027 Counters SHALL be LEN_WIDTH bits wide and SHALL never wrap; a job of len 2^LEN_WIDTH-1 SHALL complete correctly.
REQ-028 op_o SHALL hold the last latched opcode in all states, including after DONE.

Reset
REQ-029 rst_i=1 at a clock edge SHALL force IDLE, counters=0, op_o=0, issue_en_o=0, busy_o=0, done_o=0, error_o=0; this SHALL also apply mid-job.
REQ-030 error_o SHALL clear only on rst_i, or on an accepted start_i in IDLE.

Configuration
REQ-031 With macro VFPU_JOB_CTRL_PERF_CNT_EN defined, the block SHALL add port cycles_o (out, 32): a counter cleared on an accepted start_i, incremented each cycle in RUN/DRAIN, saturating at 2^32-1, held after DONE, reset to 0 by rst_i.
REQ-032 Without VFPU_JOB_CTRL_PERF_CNT_EN, port cycles_o and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 len=4, MAX_OUTSTANDING=4, issue every cycle, results 3 cycles later -> 4 issues, done_o single pulse 2 cycles after the 4th result, error_o=0.
REQ-034 len=10, MAX_OUTSTANDING=2, results withheld -> issue_en_o drops after 2 issues and rises the cycle after the next result_fire_i.
REQ-035 start_i with len=0, op=5 -> no busy_o, done_o at t+1, op_o=5.
REQ-036 result_fire_i in IDLE, or issue_fire_i with issue_en_o=0 -> error_o=1 sticky; counters unchanged; cleared by the next start_i.
REQ-037 rst_i asserted mid-RUN at issued=3 -> next cycle IDLE with all outputs 0; a new start_i runs a full job correctly.
REQ-038 With VFPU_JOB_CTRL_PERF_CNT_EN, len=2 job lasting 7 busy cycles -> cycles_o=7, held after done_o.

Source files
------------

// File: rtl/vfpu_job_ctrl.sv
// Job sequencer for the VFPU operand streamer: counts issued/retired operand pairs and
// bounds in-flight work. Optional cycle counter port enabled by VFPU_JOB_CTRL_PERF_CNT_EN.
module vfpu_job_ctrl #(
  parameter int LEN_WIDTH       = 16,
  parameter int OP_WIDTH        = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [OP_WIDTH-1:0]  op_i,
  input  logic                 issue_fire_i,
  input  logic                 result_fire_i,
  output logic                 issue_en_o,
  output logic [OP_WIDTH-1:0]  op_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
  output logic [31:0]          cycles_o,
`endif
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] retired_q, retired_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic                 error_q, error_d;

  logic [LEN_WIDTH-1:0] outstanding;
  logic                 start_acc;
  logic                 issue_en;
  logic                 issue_cnt;
  logic                 result_ok;
  logic                 result_cnt;
  logic                 proto_err;

  // Handshake: a fire input means the streamer completed a valid&ready transfer this cycle;
  // issue fires only count while issue_en_o is high, everything else is a protocol error.
  assign start_acc   = (state_q == S_IDLE) && start_i;
  assign outstanding = issued_q - retired_q;
  assign issue_en    = (state_q == S_RUN) && (issued_q < len_q) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign issue_cnt   = issue_fire_i && issue_en;
  assign result_ok   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (retired_q < issued_q);
  assign result_cnt  = result_fire_i && result_ok;
  assign proto_err   = (issue_fire_i && !issue_en) || (result_fire_i && !result_ok);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state, driven from registered counts so each phase change lands a cycle later
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (len_i != '0) ? S_RUN : S_DONE;
      end
      S_RUN:   if (issued_q == len_q)  state_d = S_DRAIN;
      S_DRAIN: if (retired_q == len_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o     = (state_q == S_DONE);
    issue_en_o = issue_en;
    state_o    = state_q;
  end

  always_comb begin
    len_d     = len_q;
    op_d      = op_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    error_d   = error_q | proto_err;
    if (start_acc) begin
      len_d     = len_i;
      op_d      = op_i;
      issued_d  = '0;
      retired_d = '0;
      error_d   = proto_err;
    end else begin
      if (issue_cnt)  issued_d  = issued_q + 1'b1;
      if (result_cnt) retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q     <= '0;
      op_q      <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      error_q   <= 1'b0;
    end else begin
      len_q     <= len_d;
      op_q      <= op_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
  end

  assign op_o    = op_q;
  assign error_o = error_q;

`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Saturates rather than wraps so long jobs still report a usable lower bound
  always_comb begin
    cycles_d = cycles_q;
    if (start_acc)                               cycles_d = '0;
    else if (busy_o && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif

endmodule
